// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2,
      CLR_STDY  = 2'd3
   } seq_state_e;

   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_HOLD_CYCLES    = 16;
   localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2_ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns CC_PLL lock status into a clean clk-synchronous core reset and re-arms the steady-lock flag.
// Optional lock watchdog built when PLL_SEQ_LOCK_WATCHDOG_EN is defined.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pll_locked,
   input  logic             pll_locked_stdy,
   output logic             pll_stdy_rst,
   output logic             rst_out_n,
   output logic             ready,
   output logic             lock_lost_stb,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic             pll_fault
);

   // One counter serves both the settle window and the steady-flag clear hold.
   localparam int MAX_CNT = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int SET_W   = $clog2(MAX_CNT + 1);

   seq_state_e       state;
   logic [SET_W-1:0] cnt;
   logic             lock_s;
   logic             stdy_s;
   logic             wd_expired;

   sync2_ff u_sync_lock (
      .clk   (clk),
      .rst_n (resetn),
      .d     (pll_locked),
      .q     (lock_s)
   );

   sync2_ff u_sync_stdy (
      .clk   (clk),
      .rst_n (resetn),
      .d     (pll_locked_stdy),
      .q     (stdy_s)
   );

`ifdef PLL_SEQ_LOCK_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            acquiring;

   assign acquiring  = (state == WAIT_LOCK) || (state == SETTLE);
   assign wd_expired = acquiring && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Restarts after every RUN or steady-flag clear so each retry gets a full window.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_cnt    <= '0;
         pll_fault <= 1'b0;
      end else if (wd_expired) begin
         wd_cnt    <= '0;
         pll_fault <= 1'b1;
      end else if (acquiring) begin
         wd_cnt    <= wd_cnt + WD_W'(1);
      end else begin
         wd_cnt    <= '0;
      end
   end
`else
   assign wd_expired = 1'b0;
   assign pll_fault  = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= WAIT_LOCK;
         cnt           <= '0;
         rst_out_n     <= 1'b0;
         ready         <= 1'b0;
         pll_stdy_rst  <= 1'b0;
         lock_lost_stb <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         lock_lost_stb <= 1'b0;
         if (wd_expired) begin
            state        <= CLR_STDY;
            cnt          <= '0;
            rst_out_n    <= 1'b0;
            ready        <= 1'b0;
            pll_stdy_rst <= 1'b1;
         end else begin
            unique case (state)
               WAIT_LOCK: begin
                  if (lock_s) begin
                     state <= SETTLE;
                     cnt   <= '0;
                  end
               end
               SETTLE: begin
                  // A drop always beats a release landing on the same edge.
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == SET_W'(STABLE_CYCLES - 1)) begin
                     state     <= RUN;
                     cnt       <= '0;
                     rst_out_n <= 1'b1;
                     ready     <= stdy_s;
                  end else begin
                     cnt <= cnt + SET_W'(1);
                  end
               end
               RUN: begin
                  if (!lock_s) begin
                     state         <= CLR_STDY;
                     cnt           <= '0;
                     rst_out_n     <= 1'b0;
                     ready         <= 1'b0;
                     pll_stdy_rst  <= 1'b1;
                     lock_lost_stb <= 1'b1;
                     if (lock_loss_cnt != {CNT_W{1'b1}})
                        lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
                  end else begin
                     ready <= stdy_s;
                  end
               end
               CLR_STDY: begin
                  // Lock is deliberately ignored until the hold completes.
                  if (cnt == SET_W'(HOLD_CYCLES - 1)) begin
                     state        <= WAIT_LOCK;
                     cnt          <= '0;
                     pll_stdy_rst <= 1'b0;
                  end else begin
                     cnt <= cnt + SET_W'(1);
                  end
               end
               default: begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
